omsp_dbg_uart_link: RTL

Parametrised debug-UART link layer for the openMSP430 debug interface. Combines a bit-level UART receiver (runtime baud divider, optional parity) with the sync/command/data frame state machine. Decoded register writes and read requests go to the debug register file, with memory-burst continuation. Sits between the synchronized `dbg_uart_rxd` pin and the debug register block, all in the `dbg_clk` domain.

---
 rtl/omsp_dbg_uart_link.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/omsp_dbg_uart_link.sv
// Debug-UART link layer: bit-level receiver plus sync/command/data frame FSM.
// Define DBG_UART_PARITY_EN to add an even-parity bit between data bit 7 and stop.
module omsp_dbg_uart_link #(
    parameter int         DIV_W     = 16,
    parameter int         ADDR_W    = 6,
    parameter logic [7:0] SYNC_BYTE = 8'h80
) (
    input  logic              dbg_clk,
    input  logic              dbg_rst,
    input  logic              dbg_uart_rxd,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              mem_burst,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic [15:0]       dbg_din,
    output logic              dbg_wr,
    output logic              cmd_valid,
    output logic              rx_err,
    output logic              rx_busy,
    output logic [2:0]        uart_state
);
`ifdef DBG_UART_PARITY_EN
    localparam logic [3:0] STOP_K = 4'd10;
`else
    localparam logic [3:0] STOP_K = 4'd9;
`endif
    localparam logic [2:0] RX_SYNC  = 3'd0;
    localparam logic [2:0] RX_CMD   = 3'd1;
    localparam logic [2:0] RX_DATA1 = 3'd2;
    localparam logic [2:0] RX_DATA2 = 3'd3;

    typedef enum logic [1:0] {RXB_IDLE, RXB_BUSY, RXB_WAIT_HI} rxb_state_t;

    rxb_state_t       rxb_state, rxb_next;
    logic [DIV_W-1:0] div_q, cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shreg;
    logic             par_bad;
    logic             start_det, tick, stop_tick, byte_ok, byte_err;

    assign start_det = (rxb_state == RXB_IDLE) && !dbg_uart_rxd;
    assign tick      = (rxb_state == RXB_BUSY) && (cnt == '0);
    assign stop_tick = tick && (bit_idx == STOP_K);
    assign byte_ok   = stop_tick && dbg_uart_rxd && !par_bad;
    assign byte_err  = stop_tick && !(dbg_uart_rxd && !par_bad);
    assign rx_busy   = (rxb_state == RXB_BUSY);

    always_ff @(posedge dbg_clk) begin
        if (dbg_rst) rxb_state <= RXB_IDLE;
        else         rxb_state <= rxb_next;
    end

    always_comb begin
        rxb_next = rxb_state;
        case (rxb_state)
            RXB_IDLE:    if (start_det) rxb_next = RXB_BUSY;
            RXB_BUSY: begin
                if (tick && bit_idx == 4'd0 && dbg_uart_rxd) rxb_next = RXB_IDLE;
                else if (stop_tick) rxb_next = dbg_uart_rxd ? RXB_IDLE : RXB_WAIT_HI;
            end
            RXB_WAIT_HI: if (dbg_uart_rxd) rxb_next = RXB_IDLE;
            default:     rxb_next = RXB_IDLE;
        endcase
    end

    always_ff @(posedge dbg_clk) begin
        if (dbg_rst) begin
            div_q   <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (start_det) begin
            div_q   <= baud_div;
            // t0 itself is the first cycle of the half-bit wait
            cnt     <= (baud_div >> 1) - DIV_W'(1);
            bit_idx <= '0;
        end else if (rxb_state == RXB_BUSY) begin
            if (cnt == '0) begin
                cnt     <= div_q;
                bit_idx <= bit_idx + 4'd1;
                if (bit_idx >= 4'd1 && bit_idx <= 4'd8) shreg <= {dbg_uart_rxd, shreg[7:1]};
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

`ifdef DBG_UART_PARITY_EN
    // Held until the stop sample so parity and framing failures share one rx_err
    always_ff @(posedge dbg_clk) begin
        if (dbg_rst || start_det)       par_bad <= 1'b0;
        else if (tick && bit_idx == 4'd9) par_bad <= ^{shreg, dbg_uart_rxd};
    end
`else
    assign par_bad = 1'b0;
`endif

    logic [2:0]        state_q, state_d;
    logic              mode_q, mode_d;
    logic [7:0]        low_q, low_d;
    logic [ADDR_W-1:0] addr_d;
    logic [15:0]       din_d;
    logic              wr_d, cv_d;

    always_ff @(posedge dbg_clk) begin
        if (dbg_rst) begin
            state_q   <= RX_SYNC;
            mode_q    <= 1'b0;
            low_q     <= '0;
            dbg_addr  <= '0;
            dbg_din   <= '0;
            dbg_wr    <= 1'b0;
            cmd_valid <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            low_q     <= low_d;
            dbg_addr  <= addr_d;
            dbg_din   <= din_d;
            dbg_wr    <= wr_d;
            cmd_valid <= cv_d;
            rx_err    <= byte_err;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_SYNC:  if (byte_ok && shreg == SYNC_BYTE) state_d = RX_CMD;
            RX_CMD:   if (byte_ok && shreg[7]) state_d = RX_DATA1;
            RX_DATA1: if (byte_ok) state_d = !mode_q ? RX_DATA2 : (mem_burst ? RX_DATA1 : RX_CMD);
            RX_DATA2: if (byte_ok) state_d = mem_burst ? RX_DATA1 : RX_CMD;
            default:  state_d = RX_SYNC;
        endcase
        if (byte_err) state_d = RX_SYNC;
    end

    always_comb begin
        mode_d = mode_q;
        low_d  = low_q;
        addr_d = dbg_addr;
        din_d  = dbg_din;
        wr_d   = 1'b0;
        cv_d   = 1'b0;
        if (byte_ok) begin
            case (state_q)
                RX_CMD: begin
                    addr_d = shreg[ADDR_W-1:0];
                    mode_d = shreg[6];
                    cv_d   = !shreg[7];
                end
                RX_DATA1: begin
                    if (mode_q) begin
                        din_d = {8'h00, shreg};
                        wr_d  = 1'b1;
                    end else begin
                        low_d = shreg;
                    end
                end
                RX_DATA2: begin
                    din_d = {shreg, low_q};
                    wr_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign uart_state = state_q;
endmodule
